// File: rtl/vga_text_writer.sv
// Byte-stream writer for the 80x60 text framebuffer: turns accepted bytes into registered
// framebuffer writes with terminal-style cursor handling, line blanking and screen clear.
module vga_text_writer #(
  parameter int unsigned HTILES     = 80,
  parameter int unsigned VTILES     = 60,
  parameter int unsigned ADDR_W     = 13,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_wdata,
  output logic [6:0]        o_col,
  output logic [5:0]        o_row,
  output logic              o_busy
);

  typedef enum logic [1:0] {StIdle, StEsc, StClrLine, StClrAll} state_e;

  localparam logic [6:0]        ColLast = 7'(HTILES - 1);
  localparam logic [5:0]        RowLast = 6'(VTILES - 1);
  localparam logic [ADDR_W-1:0] HtA     = ADDR_W'(HTILES);
  localparam logic [ADDR_W-1:0] AllLast = ADDR_W'(HTILES * VTILES - 1);

  state_e            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              do_print;
  logic              do_adv;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] line_last;

  // Ready also waits for the final clear write to leave the output register.
  assign o_ready   = ((state_q == StIdle) || (state_q == StEsc)) && !busy_q;
  assign accept    = i_valid && o_ready;
  assign cur_addr  = ADDR_W'(row_q) * HtA + ADDR_W'(col_q);
  assign line_last = ADDR_W'(row_q) * HtA + HtA - ADDR_W'(1);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = 1'b0;
    do_print = 1'b0;
    do_adv   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (i_data)
            8'h0A: begin
              col_d  = '0;
              do_adv = 1'b1;
            end
            8'h0D: col_d = '0;
            8'h08: begin
              if (col_q != '0) begin
                col_d   = col_q - 7'd1;
                we_d    = 1'b1;
                addr_d  = cur_addr - ADDR_W'(1);
                wdata_d = CLEAR_CHAR;
              end
            end
            8'h0C: begin
              state_d = StClrAll;
              cnt_d   = '0;
            end
            8'h1B:   state_d = StEsc;
            default: do_print = 1'b1;
          endcase
        end
      end
      StEsc: begin
        if (accept) begin
          do_print = 1'b1;
          state_d  = StIdle;
        end
      end
      StClrLine: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = CLEAR_CHAR;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == line_last) begin
          state_d = StIdle;
        end
      end
      StClrAll: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = CLEAR_CHAR;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == AllLast) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_print) begin
      we_d    = 1'b1;
      addr_d  = cur_addr;
      wdata_d = i_data;
      if (col_q == ColLast) begin
        col_d  = '0;
        do_adv = 1'b1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end

    // No scrolling: the destination row is always blanked.
    if (do_adv) begin
      row_d   = (row_q == RowLast) ? '0 : row_q + 6'd1;
      state_d = StClrLine;
      cnt_d   = ADDR_W'(row_d) * HtA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_col   = col_q;
  assign o_row   = row_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: directed scenarios plus a random byte stream, all writes checked
// against a terminal model that expands each byte into the framebuffer writes it implies.
module tb_vga_text_writer;

  localparam int HT = 80;
  localparam int VT = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready, o_we, o_busy;
  logic [12:0] o_addr;
  logic [7:0]  o_wdata;
  logic [6:0]  o_col;
  logic [5:0]  o_row;

  int total = 0;
  int bad = 0;
  int busy_orphans = 0;

  // Entries are {busy, addr, data}.
  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];
  int mcol = 0;
  int mrow = 0;
  bit mesc = 1'b0;

  vga_text_writer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_we    (o_we),
    .o_addr  (o_addr),
    .o_wdata (o_wdata),
    .o_col   (o_col),
    .o_row   (o_row),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_we) got_q.push_back({o_busy, o_addr, o_wdata});
      else if (o_busy) busy_orphans++;
    end
  end

  // ---------------- reference model ----------------
  function automatic void m_push(input bit busy, input int addr, input logic [7:0] d);
    exp_q.push_back({busy, 13'(addr), d});
  endfunction

  function automatic void m_newline();
    mrow = (mrow + 1) % VT;
    for (int k = 0; k < HT; k++) m_push(1'b1, mrow * HT + k, 8'h20);
  endfunction

  function automatic void m_put(input logic [7:0] b);
    m_push(1'b0, mrow * HT + mcol, b);
    mcol++;
    if (mcol == HT) begin
      mcol = 0;
      m_newline();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (mesc) begin
      mesc = 1'b0;
      m_put(b);
    end else begin
      case (b)
        8'h0A: begin mcol = 0; m_newline(); end
        8'h0D: mcol = 0;
        8'h08: if (mcol > 0) begin mcol--; m_push(1'b0, mrow * HT + mcol, 8'h20); end
        8'h0C: begin
          for (int i = 0; i < HT * VT; i++) m_push(1'b1, i, 8'h20);
          mcol = 0;
          mrow = 0;
        end
        8'h1B: mesc = 1'b1;
        default: m_put(b);
      endcase
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] b, output int waited);
    logic r;
    bit   done;
    waited  = 0;
    done    = 1'b0;
    i_data  = b;
    i_valid = 1'b1;
    while (!done) begin
      r = o_ready;
      @(posedge clk);
      #1;
      if (r) begin
        done = 1'b1;
        model_byte(b);
      end else begin
        waited++;
        if (waited > 6000) begin
          total++;
          bad++;
          $display("FAIL send_timeout: byte %02h not accepted after %0d cycles", b, waited);
          done = 1'b1;
        end
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    int w;
    send(b, w);
  endtask

  task automatic drain();
    int n = 0;
    while (!(o_ready && !o_busy) && n < 7000) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 7000) begin
      bad++;
      $display("FAIL drain_timeout: writer still busy after %0d cycles", n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name);
    int idx = -1;
    total++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (idx < 0 && got_q[i] !== exp_q[i]) idx = i;
    end
    if (got_q.size() != exp_q.size() || idx >= 0) begin
      bad++;
      if (idx >= 0)
        $display("FAIL %s: write #%0d got {busy,addr,data}=%h required %h", name, idx,
                 got_q[idx], exp_q[idx]);
      else
        $display("FAIL %s: write count got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string name);
    total++;
    if (o_col !== 7'(mcol) || o_row !== 6'(mrow)) begin
      bad++;
      $display("FAIL %s: cursor got (%0d,%0d) required (%0d,%0d)", name, o_col, o_row, mcol,
               mrow);
    end
  endtask

  task automatic goto_row(input int row);
    put(8'h0D);
    while (mrow != row) put(8'h0A);
    drain();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({o_we, o_addr, o_wdata, o_ready, o_busy, o_col, o_row} !== {1'b0, 13'd0, 8'd0, 1'b1,
        1'b0, 7'd0, 6'd0}) begin
      bad++;
      $display("FAIL reset: we=%b addr=%0d wdata=%h ready=%b busy=%b col=%0d row=%0d", o_we,
               o_addr, o_wdata, o_ready, o_busy, o_col, o_row);
    end
  endtask

  task automatic test_hi();
    put(8'h48);
    total++;
    if ({o_we, o_addr, o_wdata} !== {1'b1, 13'd0, 8'h48}) begin
      bad++;
      $display("FAIL hi_H: we=%b addr=%0d data=%h required 1/0/48", o_we, o_addr, o_wdata);
    end
    put(8'h69);
    total++;
    if ({o_we, o_addr, o_wdata, o_ready} !== {1'b1, 13'd1, 8'h69, 1'b1}) begin
      bad++;
      $display("FAIL hi_i: we=%b addr=%0d data=%h ready=%b required 1/1/69/1", o_we, o_addr,
               o_wdata, o_ready);
    end
    check_cursor("hi_cursor");
    drain();
    check_stream("hi_stream");
  endtask

  task automatic test_wrap();
    int errs = 0;
    goto_row(3);
    for (int i = 0; i < HT - 1; i++) put(8'($urandom_range(8'h21, 8'h7E)));
    put(8'h41);
    total++;
    if ({o_we, o_addr, o_wdata, o_busy} !== {1'b1, 13'd319, 8'h41, 1'b0}) begin
      bad++;
      $display("FAIL wrap_char: we=%b addr=%0d data=%h busy=%b required 1/319/41/0", o_we,
               o_addr, o_wdata, o_busy);
    end
    for (int k = 0; k < HT; k++) begin
      @(posedge clk);
      #1;
      if ({o_we, o_addr, o_wdata, o_busy, o_ready} !== {1'b1, 13'(320 + k), 8'h20, 1'b1, 1'b0})
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap_clear: %0d bad clear cycles, required 0", errs);
    end
    @(posedge clk);
    #1;
    total++;
    if ({o_we, o_ready, o_col, o_row} !== {1'b0, 1'b1, 7'd0, 6'd4}) begin
      bad++;
      $display("FAIL wrap_end: we=%b ready=%b col=%0d row=%0d required 0/1/0/4", o_we, o_ready,
               o_col, o_row);
    end
    drain();
    check_stream("wrap_stream");
  endtask

  task automatic test_row_wrap();
    int errs = 0;
    goto_row(VT - 1);
    for (int i = 0; i < 5; i++) put(8'($urandom_range(8'h21, 8'h7E)));
    drain();
    put(8'h0A);
    total++;
    if (o_we !== 1'b0) begin
      bad++;
      $display("FAIL rowwrap_nowrite: we=%b required 0", o_we);
    end
    for (int k = 0; k < HT; k++) begin
      @(posedge clk);
      #1;
      if ({o_we, o_addr, o_wdata} !== {1'b1, 13'(k), 8'h20}) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rowwrap_clear: %0d bad clear cycles, required 0", errs);
    end
    drain();
    total++;
    if (o_col !== 7'd0 || o_row !== 6'd0) begin
      bad++;
      $display("FAIL rowwrap_cursor: got (%0d,%0d) required (0,0)", o_col, o_row);
    end
    check_stream("rowwrap_stream");
  endtask

  task automatic test_esc_bs();
    goto_row(1);
    put(8'h31);
    put(8'h32);
    drain();
    put(8'h1B);
    put(8'h0A);
    total++;
    if ({o_we, o_addr, o_wdata, o_col, o_row, o_ready} !== {1'b1, 13'd82, 8'h0A, 7'd3, 6'd1,
        1'b1}) begin
      bad++;
      $display("FAIL esc_raw: we=%b addr=%0d data=%h col=%0d row=%0d ready=%b", o_we, o_addr,
               o_wdata, o_col, o_row, o_ready);
    end
    put(8'h08);
    total++;
    if ({o_we, o_addr, o_wdata, o_col} !== {1'b1, 13'd82, 8'h20, 7'd2}) begin
      bad++;
      $display("FAIL bs_mid: we=%b addr=%0d data=%h col=%0d required 1/82/20/2", o_we, o_addr,
               o_wdata, o_col);
    end
    put(8'h0D);
    put(8'h08);
    total++;
    if (o_we !== 1'b0 || o_col !== 7'd0) begin
      bad++;
      $display("FAIL bs_col0: we=%b col=%0d required 0/0", o_we, o_col);
    end
    drain();
    check_stream("escbs_stream");
  endtask

  task automatic test_hold_during_clear();
    int w;
    int exp_addr;
    put(8'h0A);
    exp_addr = mrow * HT + mcol;
    send(8'h5A, w);
    total++;
    if ({o_we, o_addr, o_wdata} !== {1'b1, 13'(exp_addr), 8'h5A} || w < HT) begin
      bad++;
      $display("FAIL hold_z: we=%b addr=%0d data=%h waited=%0d required 1/%0d/5a/>=%0d", o_we,
               o_addr, o_wdata, w, exp_addr, HT);
    end
    drain();
    check_stream("hold_stream");
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) b = 8'h0A;
      else if (r < 12) b = 8'h0D;
      else if (r < 20) b = 8'h08;
      else if (r < 24) b = 8'h1B;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0C && !mesc) b = 8'h41;
      end
      put(b);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check_stream("random_stream");
    check_cursor("random_cursor");
  endtask

  task automatic test_clear_all();
    int errs = 0;
    put(8'h0C);
    for (int k = 0; k < HT * VT; k++) begin
      @(posedge clk);
      #1;
      if ({o_we, o_addr, o_wdata, o_ready, o_busy} !== {1'b1, 13'(k), 8'h20, 1'b0, 1'b1}) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL clrall_writes: %0d bad cycles, required 0", errs);
    end
    @(posedge clk);
    #1;
    total++;
    if ({o_we, o_ready, o_col, o_row} !== {1'b0, 1'b1, 7'd0, 6'd0}) begin
      bad++;
      $display("FAIL clrall_end: we=%b ready=%b col=%0d row=%0d required 0/1/0/0", o_we, o_ready,
               o_col, o_row);
    end
    drain();
    check_stream("clrall_stream");
  endtask

  task automatic test_clear_abort();
    put(8'h33);
    put(8'h0C);
    repeat (1000) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({o_we, o_addr} !== {1'b1, 13'd999}) begin
      bad++;
      $display("FAIL abort_pre: we=%b addr=%0d required 1/999", o_we, o_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_we, o_ready, o_busy, o_col, o_row} !== {1'b0, 1'b1, 1'b0, 7'd0, 6'd0}) begin
      bad++;
      $display("FAIL abort_reset: we=%b ready=%b busy=%b col=%0d row=%0d required 0/1/0/0/0",
               o_we, o_ready, o_busy, o_col, o_row);
    end
    got_q.delete();
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    mesc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d writes after reset, required 0", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_hi();
    test_wrap();
    test_row_wrap();
    test_esc_bs();
    test_hold_during_clear();
    test_random();
    test_clear_all();
    test_clear_abort();
    total++;
    if (busy_orphans != 0) begin
      bad++;
      $display("FAIL busy_without_write: %0d cycles, required 0", busy_orphans);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
- Writer side of the 80x60 text framebuffer: accepts a byte stream over a valid/ready handshake and turns it into framebuffer write cycles (address, data, write enable) with terminal-style cursor handling.
- Sits between a host, such as a UART receiver or CPU port, and the write port of the text-mode VGA framebuffer.
- Handles line wrap, newline, carriage return, backspace, form-feed clear and an escape for raw glyph/palette codes.
- Runs entirely in the writer clock domain.

Parameters:
HTILES, 80, columns per row (character cells)
VTILES, 60, rows per screen
ADDR_W, 13, framebuffer address width (must satisfy 2^ADDR_W >= HTILES*VTILES)
CLEAR_CHAR, 8'h20, fill byte for line/screen clear

Ports:
clk  in  1  system clock (framebuffer write-side clock)
rst_n  in  1  asynchronous active-low reset
i_data  in  8  input byte
i_valid  in  1  i_data valid
o_ready  out  1  writer can accept a byte this cycle
o_we  out  1  framebuffer write enable, one write per asserted cycle
o_addr  out  ADDR_W  framebuffer address = row*HTILES + col
o_wdata  out  8  framebuffer write data
o_col  out  7  cursor column, 0..HTILES-1
o_row  out  6  cursor row, 0..VTILES-1
o_busy  out  1  clear sequence in progress

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, col=0, row=0
  - o_we=0, o_addr=0, o_wdata=0
  - o_ready=1, o_busy=0
- Reset asserted mid-clear aborts the clear immediately. No further writes are issued.
- States:
  - IDLE
  - ESC (previous byte was 0x1B)
  - CLR_LINE (clearing one row)
  - CLR_ALL (clearing the whole screen)
- o_ready=1 in IDLE and ESC, 0 in CLR_LINE and CLR_ALL. A byte is accepted on a clk edge with i_valid && o_ready.
- Outputs o_we/o_addr/o_wdata are registered. A write caused by an accepted byte appears the cycle after acceptance, always at the cursor position held before the update. Cursor registers update on the same edge as acceptance.
- Byte handling in IDLE:
  - 0x0A (LF): col=0, row advances (see row advance). No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if col>0, col=col-1 and CLEAR_CHAR is written at the new col. If col==0, no effect.
  - 0x0C (FF): enter CLR_ALL.
  - 0x1B: enter ESC. No write.
  - Any other byte (including 0x00-0x07, 0x09, 0x0B, 0x0E-0x1A, 0x1C-0xFF): written at cursor, then col+1. If col was HTILES-1, col=0 and row advances.
- ESC: the next accepted byte is written raw at the cursor and the cursor advances exactly as for a printable byte; control codes are not interpreted. Return to IDLE. This is the path for palette bytes 0x00-0x0F and glyph codes 16/17.
- Row advance:
  - row = (row==VTILES-1) ? 0 : row+1.
  - Then enter CLR_LINE for the new row. There is no scrolling; the destination row is always blanked.
- CLR_LINE:
  - HTILES consecutive cycles of o_we=1, o_addr=newrow*HTILES+k for k=0..HTILES-1, o_wdata=CLEAR_CHAR.
  - When the printable write triggered the wrap, that write occurs in the cycle before the first clear write.
  - Then IDLE.
- CLR_ALL:
  - o_we=1 for HTILES*VTILES cycles, addresses 0..HTILES*VTILES-1 ascending, data CLEAR_CHAR.
  - Then col=0, row=0, IDLE.
- o_busy=1 exactly during CLR_LINE/CLR_ALL write cycles.
- Address arithmetic: unsigned, width ADDR_W. The maximum address HTILES*VTILES-1 = 4799 is never exceeded.
- Throughput: one byte per cycle while no clear is triggered. i_valid held with o_ready=0 is not consumed; i_data must remain stable until accepted.
- o_we=0 whenever no write is scheduled.

Test Plan:
- Reset, then stream "Hi" back-to-back from cursor (0,0) -> cycle after each accept: o_we=1 with (addr 0, 0x48), then (addr 1, 0x69); end cursor col=2, row=0; o_ready stays 1.
- Cursor at col=79, row=3, send 'A' -> write (addr 319, 0x41); then 80 writes of 0x20 at addr 320..399, with o_ready=0 and o_busy=1 throughout; end col=0, row=4.
- Cursor at row=59, col=5, send 0x0A -> no char write; rows wrap: 80 writes of 0x20 at addr 0..79; end cursor (0,0).
- Send 0x0C -> 4800 consecutive writes of 0x20, addr 0..4799, o_ready=0; then cursor (0,0), o_ready=1. Assert rst_n=0 at write 1000 in a second run -> o_we=0 immediately, o_ready=1, cursor (0,0).
- Send 0x1B, 0x0A at cursor (2,1) -> single write (addr 82, 0x0A), cursor col=3, no CLR_LINE. Send 0x08 -> write (addr 82, 0x20), col=2. Send 0x08 at col=0 -> no write.
- Hold i_valid=1 with byte 'Z' during CLR_LINE -> not accepted until o_ready returns; exactly one write of 0x5A, issued after the last clear write.
